// File: rtl/fwd_stall_ctrl.sv
// Forwarding and load-use interlock controller beside the ID/EX boundary.
// Tracks in-flight destination writes and resolves per-source bypass selects.
module fwd_stall_ctrl #(
    parameter int unsigned NUM_SRC  = 2,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [4:0]               id_rd,
    input  logic                     id_rd_we,
    input  logic                     id_is_load,
    input  logic [5*NUM_SRC-1:0]     id_rs,
    input  logic [NUM_SRC-1:0]       id_rs_used,
    input  logic                     flush,
    output logic                     stall,
    output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic [31:0]              stall_cycles
);

    localparam int unsigned REG_W = 5;

    // Index k holds the entry at depth k+1.
    logic [DEPTH-1:0] trk_v;
    logic [DEPTH-1:0] trk_ld;
    logic [REG_W-1:0] trk_rd [DEPTH];

    logic [NUM_SRC-1:0]       found;
    logic [NUM_SRC-1:0]       blocked;
    logic [SEL_W*NUM_SRC-1:0] sel_c;
    logic                     issue_c;

    // Youngest matching entry decides: forward if ready, otherwise block.
    always_comb begin
        found   = '0;
        blocked = '0;
        sel_c   = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (id_valid && id_rs_used[s] && (id_rs[REG_W*s +: REG_W] != '0)) begin
                for (int k = 0; k < DEPTH; k++) begin
                    if (!found[s] && trk_v[k] && (trk_rd[k] == id_rs[REG_W*s +: REG_W])) begin
                        found[s] = 1'b1;
                        if ((k + 1) >= int'(trk_ld[k] ? LOAD_LAT : ALU_LAT)) begin
                            sel_c[SEL_W*s +: SEL_W] = SEL_W'(k + 1);
                        end else begin
                            blocked[s] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign stall   = !rst && (|blocked);
    assign fwd_sel = rst ? '0 : sel_c;
    assign issue_c = id_valid && !stall && !flush;

    // Tracker always advances; a non-issuing cycle inserts a bubble at depth 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_v        <= '0;
            trk_ld       <= '0;
            stall_cycles <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                trk_rd[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                trk_v[k]  <= trk_v[k-1];
                trk_ld[k] <= trk_ld[k-1];
                trk_rd[k] <= trk_rd[k-1];
            end
            trk_v[0]  <= issue_c && id_rd_we && (id_rd != '0);
            trk_ld[0] <= issue_c && id_is_load;
            trk_rd[0] <= id_rd;
            if (stall && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_stall_ctrl.sv
// Directed bench for fwd_stall_ctrl at default parameters.
module tb_fwd_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rd;
    logic        id_rd_we;
    logic        id_is_load;
    logic [9:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic        flush;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;

    fwd_stall_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rd        (id_rd),
        .id_rd_we     (id_rd_we),
        .id_is_load   (id_is_load),
        .id_rs        (id_rs),
        .id_rs_used   (id_rs_used),
        .flush        (flush),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one decode-stage instruction and let combinational outputs settle.
    task automatic id_set(input logic v, input logic [4:0] rd, input logic we, input logic ld,
                          input logic [4:0] rs1, input logic [4:0] rs0, input logic [1:0] used,
                          input logic fl);
        id_valid   = v;
        id_rd      = rd;
        id_rd_we   = we;
        id_is_load = ld;
        id_rs      = {rs1, rs0};
        id_rs_used = used;
        flush      = fl;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_set(0, 0, 0, 0, 0, 0, 2'b00, 0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_sel", 32'(fwd_sel), 32'd0);
        check("reset_cnt", stall_cycles, 32'd0);

        // ALU back-to-back forwarding through all depths
        id_set(1, 5, 1, 0, 0, 0, 2'b00, 0);
        check("alu_first_stall", 32'(stall), 32'd0);
        cyc();
        id_set(1, 6, 1, 0, 5, 5, 2'b11, 0);
        check("alu_b2b_stall", 32'(stall), 32'd0);
        check("alu_b2b_sel", 32'(fwd_sel), 32'({2'd1, 2'd1}));
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 5, 2'b01, 0);
        check("alu_d3_sel", 32'(fwd_sel), 32'({2'd0, 2'd3}));
        cyc();
        id_set(1, 0, 0, 0, 0, 5, 2'b01, 0);
        check("alu_retired_sel", 32'(fwd_sel), 32'd0);
        cyc();

        // Load-use: one stall cycle then forward from depth 2
        id_set(1, 7, 1, 1, 0, 0, 2'b00, 0);
        check("lw_issue_stall", 32'(stall), 32'd0);
        cyc();
        id_set(1, 8, 1, 0, 1, 7, 2'b11, 0);
        check("lu_stall", 32'(stall), 32'd1);
        check("lu_stall_sel", 32'(fwd_sel), 32'd0);
        cyc();
        id_set(1, 8, 1, 0, 1, 7, 2'b11, 0);
        check("lu_release_stall", 32'(stall), 32'd0);
        check("lu_release_sel", 32'(fwd_sel), 32'({2'd0, 2'd2}));
        check("lu_cnt", stall_cycles, 32'd1);
        cyc();

        // Youngest match wins
        id_set(1, 3, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 3, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 3, 2'b01, 0);
        check("young_alu_stall", 32'(stall), 32'd0);
        check("young_alu_sel", 32'(fwd_sel), 32'({2'd0, 2'd1}));
        cyc();
        id_set(1, 3, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 3, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 3, 2'b01, 0);
        check("young_lw_stall", 32'(stall), 32'd1);
        check("young_lw_stall_sel", 32'(fwd_sel), 32'd0);
        cyc();
        id_set(1, 0, 0, 0, 0, 3, 2'b01, 0);
        check("young_lw_release", 32'(stall), 32'd0);
        check("young_lw_sel", 32'(fwd_sel), 32'({2'd0, 2'd2}));
        cyc();

        // x0 and unused sources
        id_set(1, 0, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 0, 2'b01, 0);
        check("x0_stall", 32'(stall), 32'd0);
        check("x0_sel", 32'(fwd_sel), 32'd0);
        cyc();
        id_set(1, 9, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 9, 9, 2'b00, 0);
        check("unused_stall", 32'(stall), 32'd0);
        id_set(1, 0, 0, 0, 9, 9, 2'b10, 0);
        check("used_src1_stall", 32'(stall), 32'd1);
        check("used_src1_sel", 32'(fwd_sel), 32'd0);
        id_set(0, 0, 0, 0, 9, 9, 2'b10, 0);
        check("invalid_id_stall", 32'(stall), 32'd0);
        cyc();
        check("cnt_after_x0", stall_cycles, 32'd2);

        // Flush during a load-use stall
        id_set(1, 10, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 11, 1, 0, 0, 10, 2'b01, 1);
        check("flush_stall", 32'(stall), 32'd1);
        cyc();
        id_set(0, 0, 0, 0, 0, 0, 2'b00, 0);
        check("post_flush_stall", 32'(stall), 32'd0);
        check("flush_cnt", stall_cycles, 32'd3);
        cyc();
        id_set(1, 0, 0, 0, 10, 11, 2'b11, 0);
        check("flush_no_issue_sel", 32'(fwd_sel), 32'({2'd3, 2'd0}));
        cyc();

        // Build up state, then reset mid-stall
        id_set(1, 12, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 13, 1, 1, 0, 12, 2'b01, 0);
        cyc();
        id_set(1, 13, 1, 1, 0, 12, 2'b01, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 13, 2'b01, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 13, 2'b01, 0);
        check("lw13_sel", 32'(fwd_sel), 32'({2'd0, 2'd2}));
        cyc();
        id_set(1, 14, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 15, 1, 0, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 16, 1, 1, 0, 0, 2'b00, 0);
        cyc();
        id_set(1, 0, 0, 0, 15, 16, 2'b11, 0);
        check("pre_rst_cnt", stall_cycles, 32'd5);
        check("pre_rst_stall", 32'(stall), 32'd1);
        check("pre_rst_sel", 32'(fwd_sel), 32'({2'd2, 2'd0}));
        rst = 1'b1;
        #1;
        check("in_rst_stall", 32'(stall), 32'd0);
        check("in_rst_sel", 32'(fwd_sel), 32'd0);
        cyc();
        rst = 1'b0;
        #1;
        check("post_rst_cnt", stall_cycles, 32'd0);
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_sel", 32'(fwd_sel), 32'd0);
        id_set(1, 0, 0, 0, 15, 14, 2'b11, 0);
        check("post_rst_sel14", 32'(fwd_sel), 32'd0);
        cyc();

        // Saturation of the stall counter
        id_set(1, 20, 1, 1, 0, 0, 2'b00, 0);
        dut.stall_cycles = 32'hFFFF_FFFE;
        cyc();
        check("sat_hold", stall_cycles, 32'hFFFF_FFFE);
        id_set(1, 21, 1, 1, 0, 20, 2'b01, 0);
        check("sat_stall1", 32'(stall), 32'd1);
        cyc();
        check("sat_cnt1", stall_cycles, 32'hFFFF_FFFF);
        id_set(1, 21, 1, 1, 0, 20, 2'b01, 0);
        cyc();
        id_set(1, 22, 1, 1, 0, 21, 2'b01, 0);
        check("sat_stall2", 32'(stall), 32'd1);
        cyc();
        check("sat_cnt2", stall_cycles, 32'hFFFF_FFFF);
        id_set(1, 22, 1, 1, 0, 21, 2'b01, 0);
        cyc();
        id_set(1, 0, 0, 0, 0, 22, 2'b01, 0);
        check("sat_stall3", 32'(stall), 32'd1);
        cyc();
        check("sat_cnt3", stall_cycles, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
